// File: rtl/health_manager_pkg.sv
// health_manager_pkg: shared fight encodings, widths and saturating damage helper
package health_manager_pkg;
  localparam int HEALTH_W = 7;
  typedef enum logic [1:0] {IDLE, FIGHT, KO, DONE} state_t;
  typedef enum logic [1:0] {WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW} winner_t;
  typedef enum logic [1:0] {PH_IDLE, PH_STARTUP, PH_ACTIVE, PH_RECOVERY} phase_t;
  // one bit wider than health so a borrow shows up in the top bit and clamps to zero
  function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] h, input logic [HEALTH_W-1:0] d);
    logic [HEALTH_W:0] r;
    r = {1'b0, h} - {1'b0, d};
    return r[HEALTH_W] ? '0 : r[HEALTH_W-1:0];
  endfunction
endpackage

// File: rtl/health_manager_vitals.sv
// player_vitals: one player's health register and stun counter
module player_vitals
  import health_manager_pkg::*;
#(
  parameter int MAX_HEALTH       = 100,
  parameter int HIT_DAMAGE       = 10,
  parameter int CHIP_DAMAGE      = 2,
  parameter int HITSTUN_FRAMES   = 12,
  parameter int BLOCKSTUN_FRAMES = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hit,
  input  logic                block,
  input  logic                reload,
  input  logic                freeze,
  output logic [HEALTH_W-1:0] health,
  output logic                stunned,
  output logic                next_zero
);
  logic [7:0] stun;
  logic [HEALTH_W-1:0] health_d;
  // a clean hit overrides a simultaneous block on the same victim
  assign health_d = hit ? sat_sub(health, HEALTH_W'(HIT_DAMAGE)) :
                    block ? sat_sub(health, HEALTH_W'(CHIP_DAMAGE)) : health;
  assign next_zero = health_d == '0;
  assign stunned = stun != '0;
  // reload on round entry; otherwise apply damage and stun unless frozen
  always_ff @(posedge clk) begin
    if (reset || reload) begin
      health <= HEALTH_W'(MAX_HEALTH);
      stun   <= '0;
    end else if (!freeze) begin
      health <= health_d;
      stun   <= hit ? 8'(HITSTUN_FRAMES) : block ? 8'(BLOCKSTUN_FRAMES) : stun - 8'(stunned);
    end
  end
endmodule

// File: rtl/health_manager.sv
// health_manager: round FSM, KO hold timer and winner logic over two player_vitals
module health_manager
  import health_manager_pkg::*;
#(
  parameter int MAX_HEALTH       = 100,
  parameter int HIT_DAMAGE       = 10,
  parameter int CHIP_DAMAGE      = 2,
  parameter int HITSTUN_FRAMES   = 12,
  parameter int BLOCKSTUN_FRAMES = 6,
  parameter int KO_HOLD_FRAMES   = 120
) (
  input  logic                clk_game,
  input  logic                reset,
  input  logic                round_start,
  input  logic                p1_hit_p2,
  input  logic                p2_hit_p1,
  input  logic                p1_blocked_by_p2,
  input  logic                p2_blocked_by_p1,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic                p1_stunned,
  output logic                p2_stunned,
  output logic                round_active,
  output logic                round_over,
  output logic [1:0]          winner,
  output logic                ko_pulse
);
  state_t state, state_d;
  winner_t win;
  logic [7:0] hold;
  logic fight, start, ko, z1, z2;
  assign fight = state == FIGHT;
  assign start = round_start && (state == IDLE || state == DONE);
  assign ko = fight && (z1 || z2);
  player_vitals #(
    .MAX_HEALTH(MAX_HEALTH), .HIT_DAMAGE(HIT_DAMAGE), .CHIP_DAMAGE(CHIP_DAMAGE),
    .HITSTUN_FRAMES(HITSTUN_FRAMES), .BLOCKSTUN_FRAMES(BLOCKSTUN_FRAMES)
  ) u_p1 (
    .clk(clk_game), .reset(reset), .hit(fight && p2_hit_p1), .block(fight && p2_blocked_by_p1),
    .reload(start), .freeze(!fight), .health(p1_health), .stunned(p1_stunned), .next_zero(z1)
  );
  player_vitals #(
    .MAX_HEALTH(MAX_HEALTH), .HIT_DAMAGE(HIT_DAMAGE), .CHIP_DAMAGE(CHIP_DAMAGE),
    .HITSTUN_FRAMES(HITSTUN_FRAMES), .BLOCKSTUN_FRAMES(BLOCKSTUN_FRAMES)
  ) u_p2 (
    .clk(clk_game), .reset(reset), .hit(fight && p1_hit_p2), .block(fight && p1_blocked_by_p2),
    .reload(start), .freeze(!fight), .health(p2_health), .stunned(p2_stunned), .next_zero(z2)
  );
  // state, KO hold timer and winner; {z1,z2} maps directly onto the winner codes
  always_ff @(posedge clk_game) begin
    if (reset) begin
      state <= IDLE;
      hold  <= '0;
      win   <= WIN_NONE;
    end else begin
      state <= state_d;
      hold  <= state == KO ? hold + 8'd1 : '0;
      win   <= start ? WIN_NONE : ko ? winner_t'({z1, z2}) : win;
    end
  end
  // next-state selection
  always_comb begin
    state_d = start ? FIGHT : ko ? KO :
              (state == KO && hold == 8'(KO_HOLD_FRAMES - 1)) ? DONE : state;
  end
  // outputs decoded from registered state; hold is zero only on the first KO cycle
  always_comb begin
    round_active = state == FIGHT;
    round_over   = state == KO || state == DONE;
    ko_pulse     = state == KO && hold == '0;
    winner       = win;
  end
endmodule

// File: tb/tb_health_manager.sv
// tb_health_manager: directed scenario tests for health_manager
module tb_health_manager;
  logic clk_game = 0, reset = 1, round_start = 0;
  logic p1_hit_p2 = 0, p2_hit_p1 = 0, p1_blocked_by_p2 = 0, p2_blocked_by_p1 = 0;
  logic [6:0] p1_health, p2_health;
  logic p1_stunned, p2_stunned, round_active, round_over, ko_pulse;
  logic [1:0] winner;
  int n_cmp = 0, n_err = 0;

  health_manager dut (
    .clk_game(clk_game), .reset(reset), .round_start(round_start),
    .p1_hit_p2(p1_hit_p2), .p2_hit_p1(p2_hit_p1),
    .p1_blocked_by_p2(p1_blocked_by_p2), .p2_blocked_by_p1(p2_blocked_by_p1),
    .p1_health(p1_health), .p2_health(p2_health), .p1_stunned(p1_stunned), .p2_stunned(p2_stunned),
    .round_active(round_active), .round_over(round_over), .winner(winner), .ko_pulse(ko_pulse)
  );

  always #5 clk_game = ~clk_game;

  task automatic tick();
    @(posedge clk_game);
    #1;
  endtask

  task automatic ev(input logic h12, input logic h21, input logic b12, input logic b21);
    p1_hit_p2 = h12; p2_hit_p1 = h21; p1_blocked_by_p2 = b12; p2_blocked_by_p1 = b21;
    tick();
    p1_hit_p2 = 0; p2_hit_p1 = 0; p1_blocked_by_p2 = 0; p2_blocked_by_p1 = 0;
  endtask

  task automatic start_round();
    round_start = 1;
    tick();
    round_start = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    reset = 0;
    n_cmp++; if (p1_health !== 7'd100 || p2_health !== 7'd100) begin n_err++; $display("FAIL reset_health got %0d/%0d want 100/100", p1_health, p2_health); end
    n_cmp++; if (round_active !== 1'b0 || round_over !== 1'b0 || ko_pulse !== 1'b0) begin n_err++; $display("FAIL reset_flags got act=%b over=%b ko=%b want 0/0/0", round_active, round_over, ko_pulse); end
    n_cmp++; if (winner !== 2'b00) begin n_err++; $display("FAIL reset_winner got %b want 00", winner); end
    ev(1, 0, 0, 0);
    n_cmp++; if (p2_health !== 7'd100 || p2_stunned !== 1'b0) begin n_err++; $display("FAIL idle_hit_ignored got %0d stun=%b want 100 stun=0", p2_health, p2_stunned); end
  endtask

  task automatic test_hit();
    int cnt = 0;
    start_round();
    n_cmp++; if (round_active !== 1'b1) begin n_err++; $display("FAIL start_active got %b want 1", round_active); end
    ev(1, 0, 0, 0);
    n_cmp++; if (p2_health !== 7'd90) begin n_err++; $display("FAIL hit_health got %0d want 90", p2_health); end
    repeat (12) begin if (p2_stunned) cnt++; tick(); end
    n_cmp++; if (cnt !== 12) begin n_err++; $display("FAIL hitstun_len got %0d want 12", cnt); end
    n_cmp++; if (p2_stunned !== 1'b0) begin n_err++; $display("FAIL hitstun_end got %b want 0", p2_stunned); end
  endtask

  task automatic test_block();
    int cnt = 0;
    ev(0, 0, 0, 1);
    n_cmp++; if (p1_health !== 7'd98 || p1_stunned !== 1'b1) begin n_err++; $display("FAIL block_health got %0d stun=%b want 98 stun=1", p1_health, p1_stunned); end
    tick();
    tick();
    ev(0, 0, 0, 1);
    n_cmp++; if (p1_health !== 7'd96) begin n_err++; $display("FAIL reblock_health got %0d want 96", p1_health); end
    repeat (6) begin if (p1_stunned) cnt++; tick(); end
    n_cmp++; if (cnt !== 6) begin n_err++; $display("FAIL blockstun_reload_len got %0d want 6", cnt); end
    n_cmp++; if (p1_stunned !== 1'b0) begin n_err++; $display("FAIL blockstun_end got %b want 0", p1_stunned); end
  endtask

  task automatic test_ko();
    repeat (8) ev(1, 0, 0, 0);
    repeat (3) ev(0, 0, 1, 0);
    n_cmp++; if (p2_health !== 7'd4 || round_active !== 1'b1) begin n_err++; $display("FAIL pre_ko got %0d act=%b want 4 act=1", p2_health, round_active); end
    ev(1, 0, 0, 0);
    n_cmp++; if (p2_health !== 7'd0) begin n_err++; $display("FAIL ko_saturate got %0d want 0", p2_health); end
    n_cmp++; if (winner !== 2'b01 || ko_pulse !== 1'b1 || round_over !== 1'b1 || round_active !== 1'b0) begin n_err++; $display("FAIL ko_entry got win=%b ko=%b over=%b act=%b want 01/1/1/0", winner, ko_pulse, round_over, round_active); end
    ev(0, 1, 0, 0);
    n_cmp++; if (ko_pulse !== 1'b0) begin n_err++; $display("FAIL ko_pulse_width got %b want 0", ko_pulse); end
    n_cmp++; if (p1_health !== 7'd96 || p2_health !== 7'd0) begin n_err++; $display("FAIL ko_health_hold got %0d/%0d want 96/0", p1_health, p2_health); end
    repeat (117) tick();
    start_round();
    n_cmp++; if (round_active !== 1'b0 || round_over !== 1'b1) begin n_err++; $display("FAIL ko_start_ignored got act=%b over=%b want 0/1", round_active, round_over); end
    tick();
    start_round();
    n_cmp++; if (p1_health !== 7'd100 || p2_health !== 7'd100) begin n_err++; $display("FAIL restart_health got %0d/%0d want 100/100", p1_health, p2_health); end
    n_cmp++; if (winner !== 2'b00 || round_active !== 1'b1 || round_over !== 1'b0) begin n_err++; $display("FAIL restart_flags got win=%b act=%b over=%b want 00/1/0", winner, round_active, round_over); end
  endtask

  task automatic test_draw();
    repeat (9) ev(1, 1, 0, 0);
    n_cmp++; if (p1_health !== 7'd10 || p2_health !== 7'd10 || round_active !== 1'b1) begin n_err++; $display("FAIL pre_draw got %0d/%0d act=%b want 10/10 act=1", p1_health, p2_health, round_active); end
    ev(1, 1, 0, 0);
    n_cmp++; if (p1_health !== 7'd0 || p2_health !== 7'd0) begin n_err++; $display("FAIL draw_health got %0d/%0d want 0/0", p1_health, p2_health); end
    n_cmp++; if (winner !== 2'b11 || ko_pulse !== 1'b1) begin n_err++; $display("FAIL draw_ko got win=%b ko=%b want 11/1", winner, ko_pulse); end
    tick();
    n_cmp++; if (ko_pulse !== 1'b0 || winner !== 2'b11) begin n_err++; $display("FAIL draw_single_pulse got ko=%b win=%b want 0/11", ko_pulse, winner); end
  endtask

  task automatic test_reset_mid_ko();
    repeat (48) tick();
    reset = 1;
    tick();
    reset = 0;
    n_cmp++; if (p1_health !== 7'd100 || p2_health !== 7'd100 || p1_stunned !== 1'b0 || p2_stunned !== 1'b0) begin n_err++; $display("FAIL midko_reset_vitals got %0d/%0d stun=%b%b want 100/100 stun=00", p1_health, p2_health, p1_stunned, p2_stunned); end
    n_cmp++; if (round_active !== 1'b0 || round_over !== 1'b0 || winner !== 2'b00 || ko_pulse !== 1'b0) begin n_err++; $display("FAIL midko_reset_flags got act=%b over=%b win=%b ko=%b want 0/0/00/0", round_active, round_over, winner, ko_pulse); end
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    start_round();
    ev(1, 0, 1, 0);
    n_cmp++; if (p2_health !== 7'd90) begin n_err++; $display("FAIL hit_beats_block got %0d want 90", p2_health); end
    repeat (12) begin if (p2_stunned) cnt++; tick(); end
    n_cmp++; if (cnt !== 12 || p2_stunned !== 1'b0) begin n_err++; $display("FAIL hit_beats_block_stun got %0d end=%b want 12 end=0", cnt, p2_stunned); end
    start_round();
    n_cmp++; if (p2_health !== 7'd90 || round_active !== 1'b1) begin n_err++; $display("FAIL fight_start_ignored got %0d act=%b want 90 act=1", p2_health, round_active); end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_block();
    test_ko();
    test_draw();
    test_reset_mid_ko();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
